addsub_pipe: RTL and testbench



---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub_core.sv | 71 +++++++
 rtl/addsub_pipe.sv | 112 +++++++++++
 tb/tb_addsub_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and defaults for the pipelined add/subtract unit.
package addsub_pkg;

   localparam int ADDSUB_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_INC = 2'd2,
      OP_DEC = 2'd3
   } op_e;

   typedef struct packed {
      logic carry;
      logic zero;
   } flags_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract/increment/decrement with carry and zero flags.
// Optional saturation is enabled by defining ADDSUB_SAT_EN.
module addsub_core
   import addsub_pkg::*;
#(
   parameter int WIDTH = ADDSUB_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   output logic [WIDTH-1:0] result,
   output flags_t           flags
);

   logic [WIDTH-1:0] addend;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] shaped;

   // Every operation is one WIDTH+1 adder: a + addend + cin.
   always_comb begin
      addend = b;
      cin    = 1'b0;
      case (op)
         OP_ADD: begin
            addend = b;
            cin    = 1'b0;
         end
         OP_SUB: begin
            addend = ~b;
            cin    = 1'b1;
         end
         OP_INC: begin
            addend = '0;
            cin    = 1'b1;
         end
         OP_DEC: begin
            addend = '1;
            cin    = 1'b0;
         end
         default: begin
            addend = b;
            cin    = 1'b0;
         end
      endcase
      sum = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
   end

`ifdef ADDSUB_SAT_EN
   // Carry out of ADD/INC means overflow; missing carry on SUB/DEC means borrow.
   always_comb begin
      shaped = sum[WIDTH-1:0];
      if ((op == OP_ADD || op == OP_INC) && sum[WIDTH]) begin
         shaped = '1;
      end else if ((op == OP_SUB || op == OP_DEC) && !sum[WIDTH]) begin
         shaped = '0;
      end
   end
`else
   always_comb begin
      shaped = sum[WIDTH-1:0];
   end
`endif

   always_comb begin
      result      = shaped;
      flags.carry = sum[WIDTH];
      flags.zero  = (shaped == '0);
   end

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage valid/ready add/subtract pipeline with a consumed-result counter.
// Saturating results when built with ADDSUB_SAT_EN defined.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH   = ADDSUB_WIDTH_DEFAULT,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   input  op_e                op_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result_out,
   output logic               carry_out,
   output logic               zero_out,
   output logic [COUNT_W-1:0] count_out
);

   // Handshake: a beat transfers on any rising edge where valid && ready.
   // Producers may not assume ready before asserting valid; ready may depend
   // combinationally on the downstream ready (out_ready -> in_ready path).

   logic               s1_valid;
   logic [WIDTH-1:0]   s1_a;
   logic [WIDTH-1:0]   s1_b;
   op_e                s1_op;

   logic               s2_valid;
   logic [WIDTH-1:0]   s2_result;
   flags_t             s2_flags;

   logic [COUNT_W-1:0] count;

   logic [WIDTH-1:0]   core_result;
   flags_t             core_flags;

   logic               s2_load;
   logic               s1_advance;
   logic               accept;
   logic               consume;

   always_comb begin
      consume    = s2_valid && out_ready;
      s2_load    = !s2_valid || out_ready;
      s1_advance = s1_valid && s2_load;
      in_ready   = !s1_valid || s1_advance;
      accept     = in_valid && in_ready;
   end

   addsub_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a      (s1_a),
      .b      (s1_b),
      .op     (s1_op),
      .result (core_result),
      .flags  (core_flags)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_ADD;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_a     <= a_in;
         s1_b     <= b_in;
         s1_op    <= op_in;
      end else if (s1_advance) begin
         s1_valid <= 1'b0;
      end
   end

   // S2 keeps its data when it drains empty so outputs never glitch to junk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_flags  <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= core_result;
            s2_flags  <= core_flags;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (consume) begin
         count <= count + COUNT_W'(1);
      end
   end

   always_comb begin
      out_valid  = s2_valid;
      result_out = s2_result;
      carry_out  = s2_flags.carry;
      zero_out   = s2_flags.zero;
      count_out  = count;
   end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe (WIDTH=8, COUNT_W=4); honours ADDSUB_SAT_EN in its model.
module tb_addsub_pipe;
   import addsub_pkg::*;

`ifdef ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a_in;
   logic [7:0] b_in;
   op_e        op_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result_out;
   logic       carry_out;
   logic       zero_out;
   logic [3:0] count_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [9:0] exp_q[$];
   logic [7:0] got_q[$];
   int         cons_cyc[$];
   logic [3:0] exp_count = '0;

   addsub_pipe #(
      .WIDTH   (8),
      .COUNT_W (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_in       (a_in),
      .b_in       (b_in),
      .op_in      (op_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result_out (result_out),
      .carry_out  (carry_out),
      .zero_out   (zero_out),
      .count_out  (count_out)
   );

   // Clock/reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: integer arithmetic on the operation's meaning, not the adder.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input op_e o);
      int unsigned r;
      logic        c;
      logic [7:0]  res;
      case (o)
         OP_ADD: begin r = a + b; c = (r > 255); end
         OP_SUB: begin r = a - b; c = (a >= b); end
         OP_INC: begin r = a + 1; c = (a == 8'hFF); end
         default: begin r = a - 1; c = (a != 8'h00); end
      endcase
      res = r[7:0];
      if (SAT) begin
         if ((o == OP_ADD || o == OP_INC) && c) res = 8'hFF;
         if ((o == OP_SUB || o == OP_DEC) && !c) res = 8'h00;
      end
      return {res, c, (res == 8'h00)};
   endfunction

   // Scoreboard: every visible result must match the oldest accepted transaction.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", {31'b0, out_valid}, 32'd0);
            end else begin
               check("sb_result", {24'b0, result_out}, {24'b0, exp_q[0][9:2]});
               check("sb_carry", {31'b0, carry_out}, {31'b0, exp_q[0][1]});
               check("sb_zero", {31'b0, zero_out}, {31'b0, exp_q[0][0]});
               if (out_ready) begin
                  check("sb_count", {28'b0, count_out}, {28'b0, exp_count});
                  exp_count = exp_count + 4'd1;
                  got_q.push_back(result_out);
                  cons_cyc.push_back(cyc);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a_in, b_in, op_in));
      end
   end

   // Driver tasks
   task automatic apply_reset();
      @(posedge clk);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      exp_count = '0;
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input op_e o);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a_in     = a;
      b_in     = b;
      op_in    = o;
   endtask

   task automatic drain();
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) break;
      end
      check("drain_empty", exp_q.size(), 32'd0);
   endtask

   task automatic send_check(input logic [7:0] a, input logic [7:0] b, input op_e o,
                             input logic [7:0] er, input logic ec, input logic ez);
      drive(a, b, o);
      @(negedge clk);
      check("lat_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_not_yet", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      check("lat_valid", {31'b0, out_valid}, 32'd1);
      check("dir_result", {24'b0, result_out}, {24'b0, er});
      check("dir_carry", {31'b0, carry_out}, {31'b0, ec});
      check("dir_zero", {31'b0, zero_out}, {31'b0, ez});
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_in      = '0;
      b_in      = '0;
      op_in     = OP_ADD;
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result", {24'b0, result_out}, 32'd0);
      check("rst_carry", {31'b0, carry_out}, 32'd0);
      check("rst_zero", {31'b0, zero_out}, 32'd0);
      check("rst_count", {28'b0, count_out}, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", {31'b0, in_ready}, 32'd1);

      // Directed arithmetic with out_ready held high
      out_ready = 1'b1;
      send_check(8'hF0, 8'h20, OP_ADD, SAT ? 8'hFF : 8'h10, 1'b1, 1'b0);
      send_check(8'h05, 8'h05, OP_SUB, 8'h00, 1'b1, 1'b1);
      send_check(8'h03, 8'h05, OP_SUB, SAT ? 8'h00 : 8'hFE, 1'b0, SAT);
      send_check(8'hFF, 8'h00, OP_INC, SAT ? 8'hFF : 8'h00, 1'b1, !SAT);
      send_check(8'h00, 8'h00, OP_DEC, SAT ? 8'h00 : 8'hFF, 1'b0, SAT);
      drain();
      check("count_after_dir", {28'b0, count_out}, 32'd5);

      // Backpressure: only two of three back-to-back beats fit
      apply_reset();
      got_q.delete();
      out_ready = 1'b0;
      drive(8'd1, 8'd1, OP_ADD);
      drive(8'd2, 8'd2, OP_ADD);
      drive(8'd3, 8'd3, OP_ADD);
      @(negedge clk);
      check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_queue_depth", exp_q.size(), 32'd2);
      repeat (3) begin
         @(negedge clk);
         check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_hold_result", {24'b0, result_out}, 32'h02);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_in_ready_rise", {31'b0, in_ready}, 32'd1);
      drain();
      check("bp_got_n", got_q.size(), 32'd3);
      if (got_q.size() == 3) begin
         check("bp_order0", {24'b0, got_q[0]}, 32'h02);
         check("bp_order1", {24'b0, got_q[1]}, 32'h04);
         check("bp_order2", {24'b0, got_q[2]}, 32'h06);
      end
      check("bp_count", {28'b0, count_out}, 32'd3);

      // Asynchronous reset with both stages full and a nonzero count
      out_ready = 1'b0;
      drive(8'h11, 8'h22, OP_ADD);
      drive(8'h33, 8'h01, OP_SUB);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("full_out_valid", {31'b0, out_valid}, 32'd1);
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", {31'b0, out_valid}, 32'd0);
      check("arst_count", {28'b0, count_out}, 32'd0);
      check("arst_result", {24'b0, result_out}, 32'd0);
      exp_q.delete();
      exp_count = '0;
      @(posedge clk);
      #2;
      rst       = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("no_stale", {31'b0, out_valid}, 32'd0);
      end

      // Full throughput: 17 beats, counter wraps at 16
      apply_reset();
      cons_cyc.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drive(8'($urandom), 8'($urandom), op_e'($urandom_range(0, 3)));
         @(negedge clk);
         check("tp_in_ready", {31'b0, in_ready}, 32'd1);
      end
      drain();
      check("tp_n", cons_cyc.size(), 32'd17);
      if (cons_cyc.size() == 17) check("tp_no_bubble", cons_cyc[16] - cons_cyc[0], 32'd16);
      check("tp_count_wrap", {28'b0, count_out}, 32'd1);

      // Random traffic with random stalls on both sides
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         a_in      = 8'($urandom);
         b_in      = 8'($urandom);
         op_in     = op_e'($urandom_range(0, 3));
      end
      drain();
      check("rand_count", {28'b0, count_out}, {28'b0, exp_count});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
